isp_sobel: RTL

ISP_SOBEL -- requirements
Module: isp_sobel

---
 rtl/isp_pkg.sv | 18 +
 rtl/isp_linebuf.sv | 32 +++
 rtl/isp_sobel.sv | 136 +++++++++++++
 3 files changed

// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared pixel/gradient widths and helpers for the ISP pipeline
package isp_pkg;
  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int SAT_MAX = 255;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  function automatic grad_t widen(input pix_t p);
    return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // Gradients are bounded by +/-1020, so negation never overflows.
  function automatic logic [GRAD_W-1:0] grad_abs(input grad_t g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction
endpackage

// File: rtl/isp_linebuf.sv
// rtl/isp_linebuf.sv - single-line pixel delay, DEPTH accepted pixels deep
import isp_pkg::*;

module isp_linebuf #(
  parameter int DEPTH = 1920
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t           mem [DEPTH];
  logic [AW-1:0]  ptr;

  // Read-before-write at the same slot gives exactly DEPTH pixels of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/isp_sobel.sv
// rtl/isp_sobel.sv - 3x3 Sobel edge magnitude, three-stage stall-together pipeline
import isp_pkg::*;

module isp_sobel #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int THRESH     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_m_gray,
  input  logic             valid_m,
  output logic             ready_m,
  output logic             valid_s,
  input  logic             ready_s,
  output logic [PIX_W-1:0] data_s_edge
);
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  logic          en, accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          line1, line2;

  assign en      = ready_s || !valid_s;
  assign ready_m = en;
  assign accept  = valid_m && en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_WIDTH-1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  isp_linebuf #(.DEPTH(IMG_WIDTH)) u_line1 (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .din (data_m_gray),
    .dout(line1)
  );

  isp_linebuf #(.DEPTH(IMG_WIDTH)) u_line2 (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .din (line1),
    .dout(line2)
  );

  // Stage 1: window p[r][c], r=0 is two lines up, c=2 is the newest column.
  pix_t p [3][3];
  logic v1, m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          p[r][c] <= '0;
      v1 <= 1'b0;
      m1 <= 1'b0;
    end else if (en) begin
      v1 <= valid_m;
      if (valid_m) begin
        for (int r = 0; r < 3; r++) begin
          p[r][0] <= p[r][1];
          p[r][1] <= p[r][2];
        end
        p[0][2] <= line2;
        p[1][2] <= line1;
        p[2][2] <= data_m_gray;
        m1      <= (row < RW'(2)) || (col < CW'(2));
      end
    end
  end

  // Stage 2: gradients
  grad_t gx_c, gy_c, gx, gy;
  logic  v2, m2;

  assign gx_c = (widen(p[0][2]) + (widen(p[1][2]) <<< 1) + widen(p[2][2]))
              - (widen(p[0][0]) + (widen(p[1][0]) <<< 1) + widen(p[2][0]));
  assign gy_c = (widen(p[2][0]) + (widen(p[2][1]) <<< 1) + widen(p[2][2]))
              - (widen(p[0][0]) + (widen(p[0][1]) <<< 1) + widen(p[0][2]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx <= '0;
      gy <= '0;
      v2 <= 1'b0;
      m2 <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        gx <= gx_c;
        gy <= gy_c;
        m2 <= m1;
      end
    end
  end

  // Stage 3: magnitude shaping into the output register
  logic [GRAD_W-1:0] mag;
  pix_t              edge_px;

  assign mag = grad_abs(gx) + grad_abs(gy);

  always_comb begin
    edge_px = '0;
    if (!m2) begin
      if (THRESH == 0)
        edge_px = (mag > GRAD_W'(SAT_MAX)) ? pix_t'(SAT_MAX) : mag[PIX_W-1:0];
      else
        edge_px = (int'(mag) >= THRESH) ? pix_t'(SAT_MAX) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s     <= 1'b0;
      data_s_edge <= '0;
    end else if (en) begin
      valid_s <= v2;
      if (v2) data_s_edge <= edge_px;
    end
  end
endmodule
